// File: rtl/div_seq_ctrl_if.sv
// Bundle of the upstream operand stream, downstream result slot and divider START/DONE bus.
// slave is the controller's view; master is the view of whatever surrounds it.
interface div_seq_ctrl_if #(parameter int LEN = 16);
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] in_a;
  logic [LEN-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic [LEN-1:0] out_q;
  logic [LEN-1:0] out_r;
  logic           out_dz;
  logic           div_start;
  logic           div_done;
  logic [LEN-1:0] div_a;
  logic [LEN-1:0] div_b;
  logic [LEN-1:0] div_q;
  logic [LEN-1:0] div_r;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, div_done, div_q, div_r,
    output in_ready, out_valid, out_q, out_r, out_dz, div_start, div_a, div_b
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, div_done, div_q, div_r,
    input  in_ready, out_valid, out_q, out_r, out_dz, div_start, div_a, div_b
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Valid/ready front-end for a sequential START/DONE divider with a registered result slot,
// local divide-by-zero resolution and a sticky watchdog on a hung divider.
//
// state  | meaning
// IDLE   | waiting for an operand pair (in_ready=1)
// LAUNCH | pulsing div_start, clearing the watchdog
// BUSY   | divider running, or result ready but blocked by a full slot
// ZERO   | zero divisor, waiting to write the saturated result
module div_seq_ctrl #(
  parameter int LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  div_seq_ctrl_if.slave bus,
  output logic          err
);

  localparam int             WDW      = $clog2(LEN + 3);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(LEN + 2);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, ZERO} state_t;

  state_t         state, state_nxt;
  logic [LEN-1:0] opa, opa_nxt;
  logic [LEN-1:0] opb, opb_nxt;
  logic [WDW-1:0] wd, wd_nxt;
  logic           err_nxt;
  logic           out_valid, out_valid_nxt;
  logic [LEN-1:0] out_q, out_q_nxt;
  logic [LEN-1:0] out_r, out_r_nxt;
  logic           out_dz, out_dz_nxt;
  logic           slot_ok;
  logic           slot_wr;

  assign slot_ok       = !out_valid || bus.out_ready;
  // a write wins over the drain, so back-to-back results keep out_valid high
  assign out_valid_nxt = slot_wr || (out_valid && !bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      wd        <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dz    <= 1'b0;
    end else begin
      state     <= state_nxt;
      opa       <= opa_nxt;
      opb       <= opb_nxt;
      wd        <= wd_nxt;
      err       <= err_nxt;
      out_valid <= out_valid_nxt;
      out_q     <= out_q_nxt;
      out_r     <= out_r_nxt;
      out_dz    <= out_dz_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    opa_nxt    = opa;
    opb_nxt    = opb;
    wd_nxt     = wd;
    err_nxt    = err;
    slot_wr    = 1'b0;
    out_q_nxt  = out_q;
    out_r_nxt  = out_r;
    out_dz_nxt = out_dz;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          opa_nxt   = bus.in_a;
          opb_nxt   = bus.in_b;
          state_nxt = (bus.in_b == '0) ? ZERO : LAUNCH;
        end
      end
      LAUNCH: begin
        wd_nxt    = '0;
        state_nxt = BUSY;
      end
      BUSY: begin
        // watchdog only runs while the divider is still busy; a blocked slot never trips it
        if (!bus.div_done) begin
          wd_nxt = wd + WDW'(1);
          if (wd_nxt == WD_LIMIT) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (slot_ok) begin
          slot_wr    = 1'b1;
          out_q_nxt  = bus.div_q;
          out_r_nxt  = bus.div_r;
          out_dz_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      ZERO: begin
        if (slot_ok) begin
          slot_wr    = 1'b1;
          out_q_nxt  = '1;
          out_r_nxt  = opa;
          out_dz_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.div_start = (state == LAUNCH);
  assign bus.div_a     = opa;
  assign bus.div_b     = opb;
  assign bus.out_valid = out_valid;
  assign bus.out_q     = out_q;
  assign bus.out_r     = out_r;
  assign bus.out_dz    = out_dz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and randomized bench for div_seq_ctrl with a behavioural START/DONE divider
// that can be told to hang.
module tb_div_seq_ctrl;
  localparam int LEN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic err;
  int   total = 0;
  int   bad = 0;

  div_seq_ctrl_if #(.LEN(LEN)) bus();

  div_seq_ctrl #(.LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  // divider: loads on START, raises DONE LEN edges later, not affected by rst_n
  logic           dv_done = 1'b1;
  logic           hang = 1'b0;
  int             dv_cnt = 0;
  logic [LEN-1:0] dv_a = '0, dv_b = '1, dv_q = '0, dv_r = '0;

  always @(posedge clk) begin
    if (bus.div_start) begin
      dv_cnt  <= LEN;
      dv_done <= 1'b0;
      dv_a    <= bus.div_a;
      dv_b    <= bus.div_b;
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1 && !hang) begin
        dv_done <= 1'b1;
        dv_q    <= dv_a / dv_b;
        dv_r    <= dv_a % dv_b;
      end
    end
  end

  assign bus.div_done = dv_done;
  assign bus.div_q    = dv_q;
  assign bus.div_r    = dv_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
      bad++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_dz, err, bus.div_start} !== 5'b10000) begin
      $display("FAIL reset_flags got=%b required=10000",
               {bus.in_ready, bus.out_valid, bus.out_dz, err, bus.div_start});
      bad++;
    end
    total++;
    if ({bus.out_q, bus.out_r, bus.div_a, bus.div_b} !== '0) begin
      $display("FAIL reset_data q=%h r=%h a=%h b=%h required=0",
               bus.out_q, bus.out_r, bus.div_a, bus.div_b);
      bad++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    int first = -1;
    int starts = 0;
    logic [LEN-1:0] q = '0, r = '0;
    logic dz = 1'b1;
    bus.out_ready = 1'b1;
    accept(16'd100, 16'd7);
    total++;
    if (bus.div_start !== 1'b1) begin
      $display("FAIL norm_start got=%b required=1", bus.div_start);
      bad++;
    end
    for (int k = 1; k <= LEN + 4; k++) begin
      tick();
      if (bus.div_start) starts++;
      if (bus.out_valid && first < 0) begin
        first = k;
        q = bus.out_q;
        r = bus.out_r;
        dz = bus.out_dz;
      end
    end
    total++;
    if (starts != 0) begin
      $display("FAIL norm_start_width extra_pulses=%0d required=0", starts);
      bad++;
    end
    total++;
    if (first != LEN + 2) begin
      $display("FAIL norm_latency got=%0d required=%0d", first, LEN + 2);
      bad++;
    end
    total++;
    if ({q, r, dz} !== {16'd14, 16'd2, 1'b0}) begin
      $display("FAIL norm_result q=%0d r=%0d dz=%b required q=14 r=2 dz=0", q, r, dz);
      bad++;
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL norm_drain out_valid=%b required=0", bus.out_valid);
      bad++;
    end
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    accept(16'h1234, 16'h0000);
    total++;
    if ({bus.div_start, bus.out_valid} !== 2'b00) begin
      $display("FAIL zero_pre start,valid=%b required=00", {bus.div_start, bus.out_valid});
      bad++;
    end
    tick();
    total++;
    if ({bus.out_valid, bus.out_q, bus.out_r, bus.out_dz, bus.div_start} !==
        {1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0}) begin
      $display("FAIL zero_result v=%b q=%h r=%h dz=%b start=%b required v=1 q=ffff r=1234 dz=1 start=0",
               bus.out_valid, bus.out_q, bus.out_r, bus.out_dz, bus.div_start);
      bad++;
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL zero_drain out_valid=%b required=0", bus.out_valid);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bus.out_ready = 1'b0;
    accept(16'd65535, 16'd1);
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL b2b_first_timeout out_valid=%b required=1", bus.out_valid);
      bad++;
    end
    accept(16'd5, 16'd10);
    for (int k = 0; k < LEN + 4; k++) tick();
    total++;
    if ({bus.out_valid, bus.out_q, bus.out_r, bus.in_ready} !== {1'b1, 16'hFFFF, 16'h0000, 1'b0}) begin
      $display("FAIL b2b_held v=%b q=%h r=%h in_ready=%b required v=1 q=ffff r=0 in_ready=0",
               bus.out_valid, bus.out_q, bus.out_r, bus.in_ready);
      bad++;
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_q, bus.out_r, bus.out_dz, bus.in_ready} !==
        {1'b1, 16'h0000, 16'h0005, 1'b0, 1'b1}) begin
      $display("FAIL b2b_swap v=%b q=%h r=%h dz=%b in_ready=%b required v=1 q=0 r=5 dz=0 in_ready=1",
               bus.out_valid, bus.out_q, bus.out_r, bus.out_dz, bus.in_ready);
      bad++;
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL b2b_drain out_valid=%b required=0", bus.out_valid);
      bad++;
    end
  endtask

  task automatic test_hang();
    int   first = -1;
    logic rdy = 1'b0;
    logic ov = 1'b0;
    hang = 1'b1;
    bus.out_ready = 1'b1;
    accept(16'd50, 16'd5);
    for (int k = 1; k <= LEN + 6; k++) begin
      tick();
      if (err && first < 0) begin
        first = k;
        rdy = bus.in_ready;
      end
      if (bus.out_valid) ov = 1'b1;
    end
    total++;
    if (first != LEN + 3) begin
      $display("FAIL hang_err_time got=%0d required=%0d", first, LEN + 3);
      bad++;
    end
    total++;
    if ({rdy, ov} !== 2'b10) begin
      $display("FAIL hang_state in_ready=%b out_valid_seen=%b required 1 0", rdy, ov);
      bad++;
    end
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (err !== 1'b1) begin
      $display("FAIL hang_sticky err=%b required=1", err);
      bad++;
    end
    hang = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int first = -1;
    logic [LEN-1:0] q = '1, r = '1;
    logic dz = 1'b1;
    bus.out_ready = 1'b1;
    accept(16'd200, 16'd3);
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.in_ready, bus.out_valid, err, bus.out_r, bus.div_a, bus.div_b} !==
        {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0}) begin
      $display("FAIL rst_mid in_ready=%b v=%b err=%b r=%h a=%h b=%h required 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, err, bus.out_r, bus.div_a, bus.div_b);
      bad++;
    end
    rst_n = 1'b1;
    tick();
    accept(16'd9, 16'd3);
    for (int k = 1; k <= LEN + 6; k++) begin
      tick();
      if (bus.out_valid && first < 0) begin
        first = k;
        q = bus.out_q;
        r = bus.out_r;
        dz = bus.out_dz;
      end
    end
    total++;
    if (first != LEN + 2 || {q, r, dz} !== {16'd3, 16'd0, 1'b0}) begin
      $display("FAIL rst_restart at=%0d q=%0d r=%0d dz=%b required at=%0d q=3 r=0 dz=0",
               first, q, r, dz, LEN + 2);
      bad++;
    end
  endtask

  task automatic test_random();
    logic [2*LEN:0] exp_q[$];
    logic [LEN-1:0] a, b, cq, cr;
    logic           cdz, acc, take, pending;
    logic [2*LEN:0] e;
    int sent = 0, recvd = 0, cyc = 0, sel;
    pending = 1'b0;
    a = '0;
    b = '0;
    while (recvd < 2000 && cyc < 70000) begin
      if (!pending && sent < 2000 && $urandom_range(0, 9) != 0) begin
        a = LEN'($urandom);
        sel = $urandom_range(0, 7);
        if (sel == 0)      b = '0;
        else if (sel == 1) b = 16'd1;
        else if (sel == 2) b = LEN'($urandom_range(1, 15));
        else               b = LEN'($urandom_range(1, 65535));
        pending = 1'b1;
      end
      bus.in_valid  = pending;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      acc  = pending && bus.in_ready;
      take = bus.out_valid && bus.out_ready;
      cq   = bus.out_q;
      cr   = bus.out_r;
      cdz  = bus.out_dz;
      tick();
      cyc++;
      if (acc) begin
        if (b == '0) exp_q.push_back({16'hFFFF, a, 1'b1});
        else         exp_q.push_back({a / b, a % b, 1'b0});
        pending = 1'b0;
        sent++;
      end
      if (take) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra q=%h r=%h dz=%b required no output", cq, cr, cdz);
          bad++;
        end else begin
          e = exp_q.pop_front();
          if ({cq, cr, cdz} !== e) begin
            $display("FAIL rand_result n=%0d q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                     recvd, cq, cr, cdz, e[2*LEN:LEN+1], e[LEN:1], e[0]);
            bad++;
          end
        end
        recvd++;
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (recvd != 2000 || exp_q.size() != 0) begin
      $display("FAIL rand_count received=%0d pending=%0d required 2000 0", recvd, exp_q.size());
      bad++;
    end
    total++;
    if (err !== 1'b0) begin
      $display("FAIL rand_err err=%b required=0", err);
      bad++;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_normal();
    test_zero();
    test_back_to_back();
    test_hang();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
